// File: rtl/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: 8N1 UART receiver with byte FIFO, cts flow control and error flags.
// Define TB_UART_PARITY_EN to receive 8E1 frames and check the even-parity bit.
`timescale 1ns/1ps
module tb_uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        txd,
    output logic        cts,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overflow,
    output logic [31:0] byte_count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CTS_MAX = (AW+1)'(FIFO_DEPTH - 3);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] STOP = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef TB_UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] AFTER_DATA = PARITY;
    logic par_bad;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
    assign parity_err = 1'b0;
`endif
    logic          sync1, rx, rx_d;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push_req, tick, pop, accept;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    assign tick = cnt == ((state == START) ? LAST_HALF : LAST_FULL);
    assign byte_valid = count != '0;
    assign byte_data = byte_valid ? mem[rd_ptr] : 8'h00;
    assign pop = byte_valid & byte_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign accept = push_req & ((count != FULL) | pop);

    // rx_d trails rx by one cycle so IDLE can see the high-to-low transition.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) {rx_d, rx, sync1} <= 3'b111;
        else {rx_d, rx, sync1} <= {rx, sync1, txd};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            push_req <= 1'b0;
            frame_err <= 1'b0;
`ifdef TB_UART_PARITY_EN
            par_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            frame_err <= 1'b0;
`ifdef TB_UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            cnt <= (tick || state == IDLE || state == WAIT_HIGH) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (rx_d && !rx) state <= START;
                START: if (tick) state <= rx ? IDLE : DATA;
                DATA: if (tick) begin
                    shift <= {rx, shift[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= AFTER_DATA;
                end
`ifdef TB_UART_PARITY_EN
                PARITY: if (tick) begin
                    par_bad <= rx != ^shift;
                    parity_err <= rx != ^shift;
                    state <= STOP;
                end
                STOP: if (tick) begin
                    push_req <= rx & ~par_bad;
                    frame_err <= ~rx;
                    state <= rx ? IDLE : WAIT_HIGH;
                end
`else
                STOP: if (tick) begin
                    push_req <= rx;
                    frame_err <= ~rx;
                    state <= rx ? IDLE : WAIT_HIGH;
                end
`endif
                WAIT_HIGH: if (rx) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            byte_count <= '0;
            cts <= 1'b1;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                byte_count <= byte_count + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
            if (push_req && !accept) overflow <= 1'b1;
            cts <= (count <= CTS_MAX);
        end
    end
endmodule

// File: tb/tb_tb_uart_rx_monitor.sv
// tb_tb_uart_rx_monitor: directed bench for tb_uart_rx_monitor at CLKS_PER_BIT=16, FIFO_DEPTH=16.
// Define TB_UART_PARITY_EN for both files to exercise the 8E1 build.
`timescale 1ns/1ps
module tb_tb_uart_rx_monitor;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        txd = 1'b1;
    logic        byte_ready = 1'b0;
    logic        cts, byte_valid, frame_err, parity_err, overflow;
    logic [7:0]  byte_data;
    logic [31:0] byte_count;
    int          n_cmp = 0;
    int          n_err = 0;
    int          fe_cnt = 0;
    int          pe_cnt = 0;
    logic [7:0]  rxq [$];
`ifdef TB_UART_PARITY_EN
    logic        bad_par = 1'b0;
`endif

    tb_uart_rx_monitor #(.CLKS_PER_BIT(16), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .txd(txd), .cts(cts),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (parity_err) pe_cnt++;
        if (byte_valid && byte_ready) rxq.push_back(byte_data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 12 cycles into the stop bit: the cycle where a good byte first shows on byte_valid.
    task automatic frame(input logic [7:0] d, input logic stop);
        txd = 1'b0;
        tick(16);
        for (int b = 0; b < 8; b++) begin
            txd = d[b];
            tick(16);
        end
`ifdef TB_UART_PARITY_EN
        txd = ^d ^ bad_par;
        tick(16);
`endif
        txd = stop;
        tick(12);
    endtask

    initial begin
        rstn = 1'b0;
        tick(3);
        chk("rst_cts", cts, 1'b1);
        chk("rst_valid", byte_valid, 1'b0);
        chk("rst_data", byte_data, 8'h00);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_count", byte_count, 32'd0);
        rstn = 1'b1;
        byte_ready = 1'b1;
        tick(5);

        frame(8'h55, 1'b1);
        chk("b55_valid", byte_valid, 1'b1);
        chk("b55_data", byte_data, 8'h55);
        tick(1);
        chk("b55_valid_drop", byte_valid, 1'b0);
        chk("b55_count", byte_count, 32'd1);
        chk("b55_rx", rxq.size(), 32'd1);
        chk("b55_ferr", fe_cnt, 32'd0);
        tick(10);

        txd = 1'b0;
        tick(4);
        txd = 1'b1;
        tick(20);
        chk("glitch_valid", byte_valid, 1'b0);
        chk("glitch_count", byte_count, 32'd1);
        chk("glitch_ferr", fe_cnt, 32'd0);
        frame(8'hA3, 1'b1);
        chk("ba3_valid", byte_valid, 1'b1);
        chk("ba3_data", byte_data, 8'hA3);
        tick(10);

        frame(8'hA5, 1'b0);
        chk("ferr_pulse", fe_cnt, 32'd1);
        chk("ferr_valid", byte_valid, 1'b0);
        chk("ferr_count", byte_count, 32'd2);
        tick(44);
        chk("ferr_held", fe_cnt, 32'd1);
        chk("ferr_held_valid", byte_valid, 1'b0);
        txd = 1'b1;
        tick(10);
        frame(8'h3C, 1'b1);
        chk("b3c_valid", byte_valid, 1'b1);
        chk("b3c_data", byte_data, 8'h3C);
        chk("b3c_count", byte_count, 32'd3);
        tick(10);

        byte_ready = 1'b0;
        rxq.delete();
        for (int i = 0; i < 17; i++) begin
            frame(8'(i), 1'b1);
            tick(1);
            chk("fill_cts", cts, i <= 12);
            chk("fill_ovf", overflow, i == 16);
            tick(3);
        end
        // Three bytes were already counted before the fill.
        chk("fill_count", byte_count, 32'd19);
        chk("fill_head", byte_data, 8'h00);
        byte_ready = 1'b1;
        tick(3);
        chk("drain_cts_low", cts, 1'b0);
        tick(1);
        chk("drain_cts_high", cts, 1'b1);
        tick(20);
        chk("drain_valid", byte_valid, 1'b0);
        chk("drain_n", rxq.size(), 32'd16);
        for (int i = 0; i < 16; i++) chk("drain_order", rxq[i], 32'(i));
        chk("drain_ovf_sticky", overflow, 1'b1);

        rxq.delete();
        txd = 1'b0;
        tick(16);
        for (int b = 0; b < 4; b++) begin
            txd = b[0];
            tick(16);
        end
        txd = 1'b1;
        tick(8);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_cts", cts, 1'b1);
        chk("mid_rst_valid", byte_valid, 1'b0);
        chk("mid_rst_data", byte_data, 8'h00);
        chk("mid_rst_ferr", frame_err, 1'b0);
        chk("mid_rst_perr", parity_err, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_count", byte_count, 32'd0);
        tick(4);
        rstn = 1'b1;
        tick(5);
        frame(8'h7E, 1'b1);
        chk("b7e_valid", byte_valid, 1'b1);
        chk("b7e_data", byte_data, 8'h7E);
        tick(20);
        chk("b7e_n", rxq.size(), 32'd1);
        chk("b7e_rx", rxq.size() > 0 ? rxq[0] : 8'hFF, 8'h7E);
        chk("b7e_count", byte_count, 32'd1);
        chk("b7e_ferr", fe_cnt, 32'd1);

`ifdef TB_UART_PARITY_EN
        bad_par = 1'b1;
        frame(8'h01, 1'b1);
        bad_par = 1'b0;
        chk("par_pulse", pe_cnt, 32'd1);
        chk("par_valid", byte_valid, 1'b0);
        chk("par_count", byte_count, 32'd1);
        tick(10);
        frame(8'h01, 1'b1);
        chk("par_ok_valid", byte_valid, 1'b1);
        chk("par_ok_data", byte_data, 8'h01);
        chk("par_ok_pulse", pe_cnt, 32'd1);
        tick(10);
`else
        chk("no_par_pulse", pe_cnt, 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
